// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus: RAM read port, redirect input and the
// instruction-register valid/ready handshake.
// master = fetch unit side, slave = RAM / control unit / IR side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              fetch_en;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_adress;
    logic [7:0]        mem_rdata;
    logic [23:0]       instr_word;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        input  fetch_en, redirect_en, redirect_addr, mem_rdata, instr_ready,
        output rd_en, rd_adress, instr_word, instr_valid, instr_pc
    );

    modport slave (
        output fetch_en, redirect_en, redirect_addr, mem_rdata, instr_ready,
        input  rd_en, rd_adress, instr_word, instr_valid, instr_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads 3-byte instructions (opcode, operand1,
// operand2) from an 8-bit RAM with one-cycle read latency, assembles a
// 24-bit word and offers it to the instruction register via valid/ready.
// Owns the fetch PC; redirect_en aborts any in-flight fetch.
// Optional macro FETCH_STATS_EN adds saturating fetch_count/stall_count.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]         fetch_count,
    output logic [15:0]         stall_count
`endif
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        IDLE,
        ISS0,
        ISS1,
        ISS2,
        CAP2,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [23:0]       word_q, word_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              xfer;

    // Only HOLD raises valid, so ready outside HOLD never counts as a transfer.
    assign xfer = valid_q & bus.instr_ready;

    assign bus.rd_en       = (state_q == ISS0) || (state_q == ISS1) || (state_q == ISS2);
    assign bus.rd_adress   = addr_q;
    assign bus.instr_word  = word_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_pc    = ipc_q;

    // Next-state logic: redirect overrides everything; the read address is
    // prepared one cycle ahead so it is already stable in each issue cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        word_d  = word_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        if (bus.redirect_en) begin
            // A HOLD transfer in this cycle still completes on the IR side;
            // only the PC source changes. The data returning next cycle lands
            // in ISS0/IDLE, which never capture, so it is dropped.
            pc_d    = bus.redirect_addr;
            addr_d  = bus.redirect_addr;
            valid_d = 1'b0;
            state_d = bus.fetch_en ? ISS0 : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.fetch_en) begin
                        state_d = ISS0;
                        addr_d  = pc_q;
                    end
                end
                ISS0: begin
                    addr_d  = pc_q + ADDR_W'(1);
                    state_d = ISS1;
                end
                ISS1: begin
                    b0_d    = bus.mem_rdata;
                    addr_d  = pc_q + ADDR_W'(2);
                    state_d = ISS2;
                end
                ISS2: begin
                    b1_d    = bus.mem_rdata;
                    state_d = CAP2;
                end
                CAP2: begin
                    word_d  = {b0_q, b1_q, bus.mem_rdata};
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (xfer) begin
                        valid_d = 1'b0;
                        pc_d    = pc_q + ADDR_W'(3);
                        if (bus.fetch_en) begin
                            state_d = ISS0;
                            addr_d  = pc_q + ADDR_W'(3);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and all registered outputs; async reset drops any partial fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RST_PC;
            addr_q  <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;

    // Saturating counters of transfers and HOLD cycles without ready; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if ((state_q == HOLD) && !bus.instr_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of per-cycle vectors for the
// basic fetch/stall/back-to-back flow, then hand-written sequences for
// redirect, address wrap, redirect-with-transfer and mid-fetch reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_fetch_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    instr_fetch_unit_if #(.ADDR_W(8)) bus ();

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    instr_fetch_unit #(
        .ADDR_W   (8),
        .RESET_PC (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one-cycle read latency.
    logic [7:0] ram [256];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (bus.rd_en) ram_q <= ram[bus.rd_adress];
    end
    assign bus.mem_rdata = ram_q;

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        exp_rd;
        logic [7:0]  exp_addr;
        logic        exp_v;
        logic [23:0] exp_word;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Checks issue outputs; address compared only when a read is expected.
    task automatic chk_rd(input string nm, input logic rd, input logic [7:0] addr);
        chk({nm, ".rd_en"}, 32'(bus.rd_en), 32'(rd));
        if (rd) chk({nm, ".rd_adress"}, 32'(bus.rd_adress), 32'(addr));
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [23:0] w, input logic [7:0] pc);
        chk({nm, ".valid"}, 32'(bus.instr_valid), 32'(v));
        if (v) begin
            chk({nm, ".word"}, 32'(bus.instr_word), 32'(w));
            chk({nm, ".pc"}, 32'(bus.instr_pc), 32'(pc));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[8'h00] = 8'h12; ram[8'h01] = 8'h34; ram[8'h02] = 8'h56;
        ram[8'h03] = 8'h78; ram[8'h04] = 8'h9A; ram[8'h05] = 8'hBC;
        ram[8'h40] = 8'hC0; ram[8'h41] = 8'hC1; ram[8'h42] = 8'hC2;
        ram[8'hFE] = 8'hEE; ram[8'hFF] = 8'hFF;
        ram[8'h10] = 8'hA1; ram[8'h11] = 8'hA2; ram[8'h12] = 8'hA3;

        //            fe    rdy   rd    addr   v     word        pc
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 24'h000000, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 24'h000000, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 24'h000000, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 24'h123456, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 24'h123456, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 24'h123456, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 24'h123456, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 24'h123456, 8'h00};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 24'h000000, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 24'h000000, 8'h00};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 24'h000000, 8'h00};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 24'h789ABC, 8'h03};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00};

        rst               = 1'b1;
        bus.fetch_en      = 1'b0;
        bus.redirect_en   = 1'b0;
        bus.redirect_addr = 8'h00;
        bus.instr_ready   = 1'b0;

        // Reset values
        nxt(); nxt();
        chk("rst.rd_en", 32'(bus.rd_en), 32'd0);
        chk("rst.rd_adress", 32'(bus.rd_adress), 32'd0);
        chk("rst.word", 32'(bus.instr_word), 32'd0);
        chk("rst.valid", 32'(bus.instr_valid), 32'd0);
        chk("rst.pc", 32'(bus.instr_pc), 32'd0);
        rst = 1'b0;

        // Table: first fetch, 4-cycle stall, back-to-back fetch with fetch_en dropped mid-fetch
        for (int i = 0; i < 16; i++) begin
            if (i != 0) nxt();
            bus.fetch_en    = tbl[i].fe;
            bus.instr_ready = tbl[i].rdy;
            chk_rd($sformatf("vec%0d", i), tbl[i].exp_rd, tbl[i].exp_addr);
            chk_out($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_word, tbl[i].exp_pc);
`ifdef FETCH_STATS_EN
            if (i == 10) begin
                chk("stats.fetch_after_stall", 32'(fetch_count), 32'd1);
                chk("stats.stall_after_stall", 32'(stall_count), 32'd4);
            end
`endif
        end

        // Redirect to 0x40 during ISS2 (pc is 6 here)
        bus.fetch_en = 1'b1; bus.instr_ready = 1'b0;
        nxt(); chk_rd("redir.iss0", 1'b1, 8'h06);
        nxt(); chk_rd("redir.iss1", 1'b1, 8'h07);
        nxt(); chk_rd("redir.iss2", 1'b1, 8'h08);
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'h40;
        nxt(); bus.redirect_en = 1'b0;
        chk_rd("redir.a40", 1'b1, 8'h40); chk_out("redir.a40", 1'b0, 24'h0, 8'h0);
        nxt(); chk_rd("redir.a41", 1'b1, 8'h41); chk_out("redir.a41", 1'b0, 24'h0, 8'h0);
        nxt(); chk_rd("redir.a42", 1'b1, 8'h42); chk_out("redir.a42", 1'b0, 24'h0, 8'h0);
        nxt(); chk_rd("redir.cap", 1'b0, 8'h00); chk_out("redir.cap", 1'b0, 24'h0, 8'h0);
        nxt(); chk_out("redir.hold", 1'b1, 24'hC0C1C2, 8'h40);
        bus.instr_ready = 1'b1; bus.fetch_en = 1'b0;
        nxt(); chk_rd("redir.idle", 1'b0, 8'h00); chk_out("redir.idle", 1'b0, 24'h0, 8'h0);

        // Wrap: fetch at 0xFE reads FE, FF, 00; next fetch at 0x01
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'hFE;
        bus.fetch_en = 1'b1; bus.instr_ready = 1'b0;
        nxt(); bus.redirect_en = 1'b0;
        chk_rd("wrap.fe", 1'b1, 8'hFE);
        nxt(); chk_rd("wrap.ff", 1'b1, 8'hFF);
        nxt(); chk_rd("wrap.00", 1'b1, 8'h00);
        nxt();
        nxt(); chk_out("wrap.hold", 1'b1, 24'hEEFF12, 8'hFE);
        bus.instr_ready = 1'b1;
        nxt(); chk_rd("wrap.next01", 1'b1, 8'h01); chk_out("wrap.next", 1'b0, 24'h0, 8'h0);
        nxt(); chk_rd("wrap.next02", 1'b1, 8'h02);
        nxt(); chk_rd("wrap.next03", 1'b1, 8'h03);
        nxt();
        nxt(); chk_out("xr.hold", 1'b1, 24'h345678, 8'h01);

        // Redirect to 0x10 coinciding with a HOLD transfer
        bus.redirect_en = 1'b1; bus.redirect_addr = 8'h10;
        nxt(); bus.redirect_en = 1'b0;
        chk_rd("xr.a10", 1'b1, 8'h10); chk_out("xr.a10", 1'b0, 24'h0, 8'h0);
`ifdef FETCH_STATS_EN
        chk("stats.fetch_xr", 32'(fetch_count), 32'd5);
        chk("stats.stall_xr", 32'(stall_count), 32'd4);
`endif
        nxt(); chk_rd("xr.a11", 1'b1, 8'h11);
        nxt(); chk_rd("xr.a12", 1'b1, 8'h12);
        nxt();
        nxt(); chk_out("xr.hold2", 1'b1, 24'hA1A2A3, 8'h10);
        nxt(); chk_rd("xr.a13", 1'b1, 8'h13);
        nxt(); chk_rd("xr.a14", 1'b1, 8'h14);

        // Asynchronous reset during ISS1
        rst = 1'b1;
        #1;
        chk("arst.rd_en", 32'(bus.rd_en), 32'd0);
        chk("arst.rd_adress", 32'(bus.rd_adress), 32'd0);
        chk("arst.word", 32'(bus.instr_word), 32'd0);
        chk("arst.valid", 32'(bus.instr_valid), 32'd0);
        chk("arst.pc", 32'(bus.instr_pc), 32'd0);
`ifdef FETCH_STATS_EN
        chk("arst.fetch_count", 32'(fetch_count), 32'd0);
        chk("arst.stall_count", 32'(stall_count), 32'd0);
`endif
        nxt(); nxt();
        rst = 1'b0; bus.fetch_en = 1'b1;
        nxt(); chk_rd("restart.a0", 1'b1, 8'h00);
        nxt(); chk_rd("restart.a1", 1'b1, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
